nexys_starship_repair_arbiter: RTL and testbench

//  Shares the single repair input bank (Sw3..Sw0 hex_combo plus the BtnR submit pulse) among the

---
 rtl/nexys_starship_repair_arbiter.sv | 176 +++++++++++++++++
 tb/tb_nexys_starship_repair_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/nexys_starship_repair_arbiter.sv
// nexys_starship_repair_arbiter
// Shares the single repair input bank (hex_combo + submit) among the four
// repair state machines (TR, BR, LR, RR) using round-robin arbitration.
// Optional inactivity timeout enabled by defining REPAIR_ARB_TIMEOUT_EN.
//
// Ports:
//   Clk, Reset_n      clock, asynchronous active-low reset
//   play_flag         arbitration runs only while 1
//   gameover_ctrl     forces the arbiter idle
//   req[3:0]          broken flags (bit0=TR, bit1=BR, bit2=LR, bit3=RR)
//   submit            single-cycle BtnR pulse
//   hex_combo[3:0]    switch combo
//   tick              single-cycle inactivity timer pulse
//   grant[3:0]        one-hot grant (registered)
//   grant_valid       grant held (registered)
//   grant_id[1:0]     granted station index, holds when grant_valid=0
//   submit_out[3:0]   submit routed to the granted station (combinational)
//   combo_out[3:0]    hex_combo while granted, else 0 (combinational)
//   timeout_flag      one-cycle pulse after a timeout revoke (registered)
module nexys_starship_repair_arbiter #(
  parameter int unsigned TIMEOUT_TICKS = 8,
  parameter int unsigned TICK_W        = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       play_flag,
  input  logic       gameover_ctrl,
  input  logic [3:0] req,
  input  logic       submit,
  input  logic [3:0] hex_combo,
  input  logic       tick,
  output logic [3:0] grant,
  output logic       grant_valid,
  output logic [1:0] grant_id,
  output logic [3:0] submit_out,
  output logic [3:0] combo_out,
  output logic       timeout_flag
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_grant, w_grant_nxt;
  logic       r_grant_valid, w_grant_valid_nxt;
  logic [1:0] r_grant_id, w_grant_id_nxt;
  logic [1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic       r_timeout_flag, w_timeout_flag_nxt;
  logic [1:0] w_idx;
  logic [1:0] w_pick;
  logic       w_found;

`ifdef REPAIR_ARB_TIMEOUT_EN
  logic [TICK_W-1:0] r_tick_cnt, w_tick_cnt_nxt;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = tick & (TIMEOUT_TICKS > 0) & (TICK_W > 0);
`endif

  // Round-robin pick: first set req bit searching upward from r_rr_ptr, mod 4
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    w_idx   = r_rr_ptr;
    for (int i = 0; i < 4; i++) begin
      w_idx = r_rr_ptr + 2'(i);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state        <= ST_IDLE;
      r_grant        <= 4'h0;
      r_grant_valid  <= 1'b0;
      r_grant_id     <= 2'd0;
      r_rr_ptr       <= 2'd0;
      r_timeout_flag <= 1'b0;
`ifdef REPAIR_ARB_TIMEOUT_EN
      r_tick_cnt     <= '0;
`endif
    end else begin
      r_state        <= w_state_nxt;
      r_grant        <= w_grant_nxt;
      r_grant_valid  <= w_grant_valid_nxt;
      r_grant_id     <= w_grant_id_nxt;
      r_rr_ptr       <= w_rr_ptr_nxt;
      r_timeout_flag <= w_timeout_flag_nxt;
`ifdef REPAIR_ARB_TIMEOUT_EN
      r_tick_cnt     <= w_tick_cnt_nxt;
`endif
    end
  end

  // Next-state logic; game over / not playing overrides everything
  always_comb begin
    w_state_nxt        = r_state;
    w_grant_nxt        = r_grant;
    w_grant_valid_nxt  = r_grant_valid;
    w_grant_id_nxt     = r_grant_id;
    w_rr_ptr_nxt       = r_rr_ptr;
    w_timeout_flag_nxt = 1'b0;
`ifdef REPAIR_ARB_TIMEOUT_EN
    w_tick_cnt_nxt     = r_tick_cnt;
`endif
    if (!play_flag || gameover_ctrl) begin
      w_state_nxt       = ST_IDLE;
      w_grant_nxt       = 4'h0;
      w_grant_valid_nxt = 1'b0;
      w_rr_ptr_nxt      = 2'd0;
`ifdef REPAIR_ARB_TIMEOUT_EN
      w_tick_cnt_nxt    = '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            w_state_nxt       = ST_GRANT;
            w_grant_nxt       = 4'b0001 << w_pick;
            w_grant_valid_nxt = 1'b1;
            w_grant_id_nxt    = w_pick;
`ifdef REPAIR_ARB_TIMEOUT_EN
            w_tick_cnt_nxt    = '0;
`endif
          end
        end
        ST_GRANT: begin
          if (!req[r_grant_id]) begin
            w_state_nxt       = ST_RELEASE;
            w_grant_nxt       = 4'h0;
            w_grant_valid_nxt = 1'b0;
            w_rr_ptr_nxt      = r_grant_id + 2'd1;
          end
`ifdef REPAIR_ARB_TIMEOUT_EN
          else if (tick && !submit && (r_tick_cnt == TICK_W'(TIMEOUT_TICKS - 1))) begin
            w_state_nxt        = ST_RELEASE;
            w_grant_nxt        = 4'h0;
            w_grant_valid_nxt  = 1'b0;
            w_rr_ptr_nxt       = r_grant_id + 2'd1;
            w_timeout_flag_nxt = 1'b1;
          end else if (submit) begin
            w_tick_cnt_nxt = '0;
          end else if (tick && (r_tick_cnt != {TICK_W{1'b1}})) begin
            w_tick_cnt_nxt = r_tick_cnt + TICK_W'(1);
          end
`endif
        end
        ST_RELEASE: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt       = ST_IDLE;
          w_grant_nxt       = 4'h0;
          w_grant_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  assign grant        = r_grant;
  assign grant_valid  = r_grant_valid;
  assign grant_id     = r_grant_id;
  assign timeout_flag = r_timeout_flag;

  // Routing is zero-latency so a submit in the req-drop cycle still reaches the station
  assign submit_out = r_grant & {4{submit}};
  assign combo_out  = r_grant_valid ? hex_combo : 4'h0;

endmodule

// File: tb/tb_nexys_starship_repair_arbiter.sv
// Scoreboard bench for nexys_starship_repair_arbiter: each step drives inputs
// on the falling edge and queues the outputs expected in that cycle; a monitor
// pops and compares shortly after.
module tb_nexys_starship_repair_arbiter;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       play_flag = 1'b0;
  logic       gameover_ctrl = 1'b0;
  logic [3:0] req = 4'h0;
  logic       submit = 1'b0;
  logic [3:0] hex_combo = 4'h0;
  logic       tick = 1'b0;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic [3:0] submit_out;
  logic [3:0] combo_out;
  logic       timeout_flag;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string      tag;
    logic [3:0] grant;
    logic       valid;
    logic [1:0] id;
    logic [3:0] sout;
    logic [3:0] cout;
    logic       tf;
  } exp_t;

  exp_t sb[$];

  nexys_starship_repair_arbiter #(
    .TIMEOUT_TICKS(3),
    .TICK_W       (4)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .play_flag    (play_flag),
    .gameover_ctrl(gameover_ctrl),
    .req          (req),
    .submit       (submit),
    .hex_combo    (hex_combo),
    .tick         (tick),
    .grant        (grant),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .submit_out   (submit_out),
    .combo_out    (combo_out),
    .timeout_flag (timeout_flag)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected during it
  task automatic step(input string tag, input logic rn, input logic pf, input logic go,
                      input logic [3:0] rq, input logic sm, input logic [3:0] hx, input logic tk,
                      input logic [3:0] eg, input logic ev, input logic [1:0] eid,
                      input logic [3:0] es, input logic [3:0] ec, input logic etf);
    exp_t e;
    @(negedge Clk);
    Reset_n       = rn;
    play_flag     = pf;
    gameover_ctrl = go;
    req           = rq;
    submit        = sm;
    hex_combo     = hx;
    tick          = tk;
    e.tag = tag; e.grant = eg; e.valid = ev; e.id = eid; e.sout = es; e.cout = ec; e.tf = etf;
    sb.push_back(e);
  endtask

  // Monitor: compare queued expectations mid-cycle, away from the active edge
  always @(negedge Clk) begin
    exp_t e;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".grant"},   8'(grant),        8'(e.grant));
      chk({e.tag, ".valid"},   8'(grant_valid),  8'(e.valid));
      chk({e.tag, ".id"},      8'(grant_id),     8'(e.id));
      chk({e.tag, ".sub_out"}, 8'(submit_out),   8'(e.sout));
      chk({e.tag, ".combo"},   8'(combo_out),    8'(e.cout));
      chk({e.tag, ".tflag"},   8'(timeout_flag), 8'(e.tf));
      chk({e.tag, ".onehot"},  8'($onehot0(grant)), 8'd1);
    end
  end

  initial begin
    //     tag          rn pf go req     sm hex   tk | grant  v id    sout   combo  tf
    step("reset",       0, 0, 0, 4'h0,   1, 4'hF, 0,  4'h0,  0, 2'd0, 4'h0,  4'h0,  0);
    // Round robin from rr_ptr=0: BR first, then RR after release
    step("rr_req",      1, 1, 0, 4'b1010,0, 4'hA, 0,  4'h0,  0, 2'd0, 4'h0,  4'h0,  0);
    step("br_submit",   1, 1, 0, 4'b1010,1, 4'hA, 0,  4'b0010,1,2'd1, 4'b0010,4'hA, 0);
    step("br_drop",     1, 1, 0, 4'b1000,0, 4'hA, 0,  4'b0010,1,2'd1, 4'h0,  4'hA,  0);
    step("release_sub", 1, 1, 0, 4'b1000,1, 4'hA, 0,  4'h0,  0, 2'd1, 4'h0,  4'h0,  0);
    step("idle_sub",    1, 1, 0, 4'b1000,1, 4'hA, 0,  4'h0,  0, 2'd1, 4'h0,  4'h0,  0);
    // RR granted; game over revokes it and resets rr_ptr
    step("rr_gameover", 1, 1, 1, 4'b1000,0, 4'h3, 0,  4'b1000,1,2'd3, 4'h0,  4'h3,  0);
    step("go_idle",     1, 1, 0, 4'b1001,0, 4'h3, 0,  4'h0,  0, 2'd3, 4'h0,  4'h0,  0);
    step("go_tr",       1, 1, 0, 4'b1001,0, 4'h3, 0,  4'b0001,1,2'd0, 4'h0,  4'h3,  0);
    // TR releases; LR granted from rr_ptr=1
    step("tr_drop",     1, 1, 0, 4'b0100,0, 4'h0, 0,  4'b0001,1,2'd0, 4'h0,  4'h0,  0);
    step("rel2",        1, 1, 0, 4'b0100,0, 4'h0, 0,  4'h0,  0, 2'd0, 4'h0,  4'h0,  0);
    step("idle2",       1, 1, 0, 4'b0100,0, 4'h0, 0,  4'h0,  0, 2'd0, 4'h0,  4'h0,  0);
    step("lr_sub",      1, 1, 0, 4'b0100,1, 4'h5, 0,  4'b0100,1,2'd2, 4'b0100,4'h5, 0);
    // Async reset mid-grant clears everything immediately
    step("async_rst",   0, 1, 0, 4'b0100,1, 4'h5, 0,  4'h0,  0, 2'd0, 4'h0,  4'h0,  0);
    step("post_rst",    1, 1, 0, 4'b0001,0, 4'h5, 0,  4'h0,  0, 2'd0, 4'h0,  4'h0,  0);
    step("tr_after",    1, 1, 0, 4'b0001,0, 4'h5, 0,  4'b0001,1,2'd0, 4'h0,  4'h5,  0);
    // Leaving play drops the grant
    step("play_low",    1, 0, 0, 4'b0001,0, 4'h5, 0,  4'b0001,1,2'd0, 4'h0,  4'h5,  0);
    step("play_off1",   1, 0, 0, 4'b0001,1, 4'h5, 0,  4'h0,  0, 2'd0, 4'h0,  4'h0,  0);
    step("play_off2",   1, 0, 0, 4'b0011,0, 4'h5, 0,  4'h0,  0, 2'd0, 4'h0,  4'h0,  0);
    step("play_on",     1, 1, 0, 4'b0011,0, 4'h5, 0,  4'h0,  0, 2'd0, 4'h0,  4'h0,  0);
`ifdef REPAIR_ARB_TIMEOUT_EN
    // TIMEOUT_TICKS=3: a submit after tick 2 restarts the count
    step("to_tick1",    1, 1, 0, 4'b0011,0, 4'h5, 1,  4'b0001,1,2'd0, 4'h0,  4'h5,  0);
    step("to_gap",      1, 1, 0, 4'b0011,0, 4'h5, 0,  4'b0001,1,2'd0, 4'h0,  4'h5,  0);
    step("to_tick2",    1, 1, 0, 4'b0011,0, 4'h5, 1,  4'b0001,1,2'd0, 4'h0,  4'h5,  0);
    step("to_submit",   1, 1, 0, 4'b0011,1, 4'h5, 0,  4'b0001,1,2'd0, 4'b0001,4'h5, 0);
    step("to_tick_a",   1, 1, 0, 4'b0011,0, 4'h5, 1,  4'b0001,1,2'd0, 4'h0,  4'h5,  0);
    step("to_tick_b",   1, 1, 0, 4'b0011,0, 4'h5, 1,  4'b0001,1,2'd0, 4'h0,  4'h5,  0);
    step("to_tick_c",   1, 1, 0, 4'b0011,0, 4'h5, 1,  4'b0001,1,2'd0, 4'h0,  4'h5,  0);
    step("to_flag",     1, 1, 0, 4'b0011,0, 4'h5, 0,  4'h0,  0, 2'd0, 4'h0,  4'h0,  1);
    step("to_idle",     1, 1, 0, 4'b0011,0, 4'h5, 0,  4'h0,  0, 2'd0, 4'h0,  4'h0,  0);
    step("to_br",       1, 1, 0, 4'b0011,0, 4'h5, 0,  4'b0010,1,2'd1, 4'h0,  4'h5,  0);
`else
    // Without the timeout, ticks never revoke the grant
    for (int i = 0; i < 20; i++)
      step("no_to_tick",1, 1, 0, 4'b0011,0, 4'h5, 1,  4'b0001,1,2'd0, 4'h0,  4'h5,  0);
    step("no_to_end",   1, 1, 0, 4'b0011,0, 4'h5, 0,  4'b0001,1,2'd0, 4'h0,  4'h5,  0);
`endif
    @(negedge Clk);
    #4;
    chk("sb_empty", 8'(sb.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
